// File: rtl/digit_scan_controller.sv
// Scans a 4-digit common-anode seven-segment display; optional LEADING_ZERO_BLANK_EN darkens leading zero digits.
// Latency: first anode low BLANK_CYC+1 cycles after enable_i is sampled high; all outputs registered.
// No backpressure: update_i is always accepted; new values reach the display only at frame boundaries.
module digit_scan_controller #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic        clk_i,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        update_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_i,
    output logic [3:0]  digit_sel_o,
    output logic [3:0]  bcd_o,
    output logic        dp_o,
    output logic        frame_done_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_ON} state_t;

    // With no dead time a slot opens directly in ON
    localparam state_t SLOT_START = (BLANK_CYC == 0) ? S_ON : S_BLANK;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;

    logic [15:0] shadow, pending;
    logic [3:0]  shadow_dp, pending_dp;
    logic        pending_vld;

    logic        boundary, load_shadow, suppress;
    logic [3:0]  sel_d, bcd_d;
    logic        dp_d, frame_d;

    // Last cycle of digit 3's slot: the only point where the shown value may change
    assign boundary    = enable_i && (state == S_ON) && (cnt == CNT_LAST) && (idx == 2'd3);
    // Leaving OFF also counts as a frame start, so the first frame shows the newest value
    assign load_shadow = boundary || (enable_i && (state == S_OFF));

    // State register: slot position and digit index
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_OFF;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: blank dead time, lit time, slot wrap and digit advance
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (!enable_i) begin
            state_nxt = S_OFF;
            cnt_nxt   = '0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = SLOT_START;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
                S_BLANK: begin
                    cnt_nxt = cnt + CNT_ONE;
                    if (cnt == BLANK_LAST) begin
                        state_nxt = S_ON;
                    end
                end
                S_ON: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        idx_nxt   = idx + 2'd1;
                        state_nxt = SLOT_START;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more-significant nibble are zero and its point is off
    always_comb begin
        suppress = 1'b0;
        case (idx)
            2'd1:    suppress = (shadow[15:4]  == 12'h000) && !shadow_dp[1];
            2'd2:    suppress = (shadow[15:8]  == 8'h00)   && !shadow_dp[2];
            2'd3:    suppress = (shadow[15:12] == 4'h0)    && !shadow_dp[3];
            default: suppress = 1'b0;
        endcase
    end
`else
    assign suppress = 1'b0;
`endif

    // Output decode: one anode low only while lit, everything dark otherwise
    always_comb begin
        sel_d   = 4'hF;
        bcd_d   = 4'h0;
        dp_d    = 1'b1;
        frame_d = boundary;
        if (enable_i && (state == S_ON) && !suppress) begin
            sel_d = ~(4'b0001 << idx);
            bcd_d = shadow[{idx, 2'b00} +: 4];
            dp_d  = ~shadow_dp[idx];
        end
    end

    // Output registers keep every output free of input-to-output paths
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            digit_sel_o  <= 4'hF;
            bcd_o        <= 4'h0;
            dp_o         <= 1'b1;
            frame_done_o <= 1'b0;
        end else begin
            digit_sel_o  <= sel_d;
            bcd_o        <= bcd_d;
            dp_o         <= dp_d;
            frame_done_o <= frame_d;
        end
    end

    // Pending/shadow pair: last strobe wins, shadow only moves at a frame start
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= '0;
            shadow_dp   <= '0;
            pending     <= '0;
            pending_dp  <= '0;
            pending_vld <= 1'b0;
        end else if (load_shadow) begin
            if (update_i) begin
                shadow    <= digits_i;
                shadow_dp <= dp_i;
            end else if (pending_vld) begin
                shadow    <= pending;
                shadow_dp <= pending_dp;
            end
            pending_vld <= 1'b0;
        end else if (update_i) begin
            pending     <= digits_i;
            pending_dp  <= dp_i;
            pending_vld <= 1'b1;
        end
    end

endmodule
